window3x3_gen: RTL and testbench
================================

// Module: window3x3_gen
// PURPOSE
//  Producer side of the nine-operand interface (c1..c9) used by the summing stages.
//  Converts a raster pixel stream into a sliding 3x3 neighbourhood and presents it as nine taps.
//  It sits at the pipeline head and feeds the per-tap multiply stage ahead of the 9-input adders.
// PARAMETERS
//  DATA_W  8   pixel / tap width in bits
//  LINE_W  64  pixels per image line (>=3)
//  COL_W   $clog2(LINE_W)  column counter width (localparam, derived)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  in_valid   in   1       pixel qualifier; no backpressure, gaps allowed
//  in_sof     in   1       start of frame; sampled only with in_valid=1
//  in_data    in   DATA_W  pixel, raster order
//  out_valid  out  1       c1..c9 hold a complete in-frame window (1-cycle pulse per window)
//  c1..c9     out  DATA_W  taps, row-major: c1=top-left (oldest), c9=bottom-right (newest pixel)
// BEHAVIOUR
//  - Reset (rst=0, async): col=0, row=0, out_valid=0, c1..c9=0, window regs=0.
//    Line-buffer storage is not cleared; validity gating hides stale data.
//  - Accepted pixel = in_valid=1 at rising clk. Nothing changes on cycles with in_valid=0.
//    Exception: out_valid is forced to 0 on those cycles. c1..c9 hold their values.
//  - Line buffers: two delay lines of LINE_W each.
//    lb0 out = pixel one line above. lb1 out = pixel two lines above.
//    Both advance only on accepted pixels.
//  - Window shift on accept: each row shifts left by one.
//    New right column = {lb1_out, lb0_out, in_data} -> {c3, c6, c9}.
//  - Counters, (row, col) of the accepted pixel:
//    - col increments and wraps LINE_W-1 -> 0. On wrap, row increments.
//    - row saturates at 2; frame height is unlimited.
//    - in_sof=1 with in_valid=1: the pixel is (0,0). col and row restart.
//      Window regs and line buffers are not flushed.
//  - out_valid <= 1 on the cycle after accepting a pixel with row>=2 and col>=2; otherwise <= 0.
//    Latency is 1 clk from the accepting edge to out_valid/c1..c9.
//    Windows straddling a line wrap (col 0,1) are never flagged valid.
//  - Valid windows per frame: (LINE_W-2) per line from line 2 onward.
//  - Width: taps are pure copies, no arithmetic, no truncation.
//  - Reset mid-frame: immediate clear as above. The next frame needs in_sof or starts at (0,0).
//  - in_sof while row<2: restart only, no output.
//  - in_sof on the last column: restart wins over wrap.
// STRUCTURE
//  - Shared package (pixel-pipe package): DATA_W default, LINE_W default, tap index constants TAP_C1..TAP_C9.
//  - Sub-module line_buffer #(DATA_W, LINE_W): enable-gated delay line, instantiated twice in series.
//    Ports clk, rst, en, din, dout.
//  - The top holds the counters, the 3x3 register window and the valid logic.
// TESTING  (LINE_W=4, DATA_W=8, pixel value = raster index)
//  1. Frame 0..15, in_valid=1 every cycle, sof on pixel 0 -> first out_valid 1 clk after pixel 10.
//     Taps c1..c9 = 0,1,2,4,5,6,8,9,10. Exactly 4 pulses, last window = 5,6,7,9,10,11,13,14,15.
//  2. Same frame, in_valid toggling 1/0 -> identical tap sets. out_valid only after accept cycles.
//     c1..c9 held during gaps.
//  3. Line wrap: pixels 11 and 12 (col 3 -> col 0) -> no out_valid after pixel 12 or pixel 13.
//  4. in_sof asserted on pixel 6 mid-frame -> no out_valid until 2 lines + 3 pixels after it.
//     The first window then consists of post-sof pixels only.
//  5. rst=0 for 1 clk after pixel 10's accept -> out_valid=0 and c1..c9=0 asynchronously.
//     The following frame behaves exactly as test 1.
//  6. 0xFF/0x00 checkerboard -> taps show the exact pattern, no width change or sign extension.

Source files
------------

// File: rtl/window3x3_gen_pkg.sv
// Pixel-pipe shared constants: default pixel/line geometry and the tap ordering
// of the nine-operand (c1..c9) interface.
package window3x3_gen_pkg;

  localparam int PP_DATA_W = 8;
  localparam int PP_LINE_W = 64;

  // Row-major tap indices: TAP_C1 is the oldest (top-left), TAP_C9 the newest pixel.
  localparam int TAP_C1 = 0;
  localparam int TAP_C2 = 1;
  localparam int TAP_C3 = 2;
  localparam int TAP_C4 = 3;
  localparam int TAP_C5 = 4;
  localparam int TAP_C6 = 5;
  localparam int TAP_C7 = 6;
  localparam int TAP_C8 = 7;
  localparam int TAP_C9 = 8;
  localparam int NUM_TAPS = 9;

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// Enable-gated delay line of LINE_W entries: dout is the sample written LINE_W
// enabled cycles ago. Storage is deliberately left uninitialised on reset.
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int PTR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic [DATA_W-1:0] mem [LINE_W];
  logic [PTR_W-1:0]  ptr;

  // Read-before-write at the same slot yields the value from one full line ago.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_W'(LINE_W - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// Sliding 3x3 neighbourhood generator: turns a raster pixel stream into nine
// row-major taps with a one-cycle out_valid pulse per complete in-frame window.
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int DATA_W = PP_DATA_W,
  parameter int LINE_W = PP_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] c1,
  output logic [DATA_W-1:0] c2,
  output logic [DATA_W-1:0] c3,
  output logic [DATA_W-1:0] c4,
  output logic [DATA_W-1:0] c5,
  output logic [DATA_W-1:0] c6,
  output logic [DATA_W-1:0] c7,
  output logic [DATA_W-1:0] c8,
  output logic [DATA_W-1:0] c9
);

  localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic [COL_W-1:0]  col, col_cur, col_nxt;
  logic [1:0]        row, row_cur, row_nxt;
  logic [DATA_W-1:0] lb0_out, lb1_out;
  logic [DATA_W-1:0] win [NUM_TAPS];

  line_buffer #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_lb0 (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .din (in_data),
    .dout(lb0_out)
  );

  line_buffer #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_lb1 (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .din (lb0_out),
    .dout(lb1_out)
  );

  // Position of the pixel being accepted; sof overrides the running counters,
  // which also makes a restart on the last column win over the wrap.
  always_comb begin
    col_cur = in_sof ? '0 : col;
    row_cur = in_sof ? 2'd0 : row;
    col_nxt = col_cur + 1'b1;
    row_nxt = row_cur;
    if (col_cur == COL_W'(LINE_W - 1)) begin
      col_nxt = '0;
      row_nxt = (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= 2'd0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        win[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        col       <= col_nxt;
        row       <= row_nxt;
        out_valid <= (row_cur == 2'd2) && (col_cur >= COL_W'(2));
        win[TAP_C1] <= win[TAP_C2];
        win[TAP_C2] <= win[TAP_C3];
        win[TAP_C3] <= lb1_out;
        win[TAP_C4] <= win[TAP_C5];
        win[TAP_C5] <= win[TAP_C6];
        win[TAP_C6] <= lb0_out;
        win[TAP_C7] <= win[TAP_C8];
        win[TAP_C8] <= win[TAP_C9];
        win[TAP_C9] <= in_data;
      end
    end
  end

  assign c1 = win[TAP_C1];
  assign c2 = win[TAP_C2];
  assign c3 = win[TAP_C3];
  assign c4 = win[TAP_C4];
  assign c5 = win[TAP_C5];
  assign c6 = win[TAP_C6];
  assign c7 = win[TAP_C7];
  assign c8 = win[TAP_C8];
  assign c9 = win[TAP_C9];

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen with LINE_W=4: expected windows are built
// from a history of accepted pixels and compared when out_valid pulses.
module tb_window3x3_gen;

  localparam int LW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;

  window3x3_gen #(.DATA_W(DW), .LINE_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .out_valid(out_valid),
    .c1(c1), .c2(c2), .c3(c3),
    .c4(c4), .c5(c5), .c6(c6),
    .c7(c7), .c8(c8), .c9(c9)
  );

  always #5 clk = ~clk;

  wire [71:0] taps = {c1, c2, c3, c4, c5, c6, c7, c8, c9};

  int          checks = 0;
  int          errors = 0;
  logic [71:0] sb_q[$];
  int          hist[$];
  int          mrow, mcol;
  logic [71:0] mwin;
  bit          mwin_ok;
  int          pulses;
  logic [71:0] first_win, last_win, exp_w;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] model_win();
    int n = hist.size() - 1;
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w = {w[63:0], 8'(hist[n - (2 - r) * LW - (2 - k)])};
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    sb_q.delete();
    mrow    = 0;
    mcol    = 0;
    mwin_ok = 0;
  endtask

  task automatic step(input bit v, input bit s, input int d);
    bit exp_v;
    logic [71:0] w;
    in_valid = v;
    in_sof   = s;
    in_data  = 8'(d);
    @(posedge clk);
    exp_v = 0;
    if (v) begin
      if (s) begin
        mrow = 0;
        mcol = 0;
      end
      hist.push_back(d);
      exp_v = (mrow >= 2) && (mcol >= 2);
      if (hist.size() >= 2 * LW + 3) begin
        mwin    = model_win();
        mwin_ok = 1;
      end
      if (exp_v) sb_q.push_back(mwin);
      mcol++;
      if (mcol == LW) begin
        mcol = 0;
        if (mrow < 2) mrow++;
      end
    end
    #1;
    chk("out_valid", {71'd0, out_valid}, {71'd0, exp_v});
    if (out_valid) begin
      pulses++;
      if (pulses == 1) first_win = taps;
      last_win = taps;
    end
    if (exp_v && sb_q.size() > 0) begin
      w = sb_q.pop_front();
      chk("window", taps, w);
    end else if (mwin_ok) begin
      chk(v ? "shift" : "hold", taps, mwin);
    end
  endtask

  task automatic frame(input bit gaps);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, i);
      if (gaps) step(1'b0, 1'b0, 8'hEE);
    end
    chk("pulse_count", 72'(pulses), 72'd4);
    exp_w = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    chk("first_window", first_win, exp_w);
    exp_w = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    chk("last_window", last_win, exp_w);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {71'd0, out_valid}, 72'd0);
    chk("reset_taps", taps, 72'd0);
    rst = 1'b1;

    // Continuous frame, then the same frame with idle cycles between pixels
    frame(1'b0);
    frame(1'b1);

    // Mid-frame restart at pixel 6
    pulses = 0;
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, i);
    for (int i = 6; i < 22; i++) step(1'b1, i == 6, i);
    chk("sof_pulse_count", 72'(pulses), 72'd4);
    exp_w = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
    chk("sof_first_window", first_win, exp_w);

    // Asynchronous reset right after the first valid window
    for (int i = 0; i <= 10; i++) step(1'b1, i == 0, i);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {71'd0, out_valid}, 72'd0);
    chk("async_rst_taps", taps, 72'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_taps", taps, 72'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    model_reset();
    frame(1'b0);

    // 0xFF/0x00 checkerboard
    pulses = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        step(1'b1, (r == 0) && (c == 0), ((r + c) & 1) ? 255 : 0);
    chk("checker_pulses", 72'(pulses), 72'd4);
    exp_w = {8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    chk("checker_last", last_win, exp_w);

    step(1'b0, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
